// File: rtl/cond_nullify_unit_if.sv
// ALU result/flag interface between the EX-stage producer and the condition/nullify unit.
// master drives ALU flags and EX control; slave returns the condition and nullify status.
interface cond_nullify_unit_if #(
  parameter int CNT_W = 16
);
  logic             alu_valid;
  logic [3:0]       alu_flags;
  logic             alu_lsb;
  logic             update_cc;
  logic             eval_en;
  logic             use_live;
  logic [2:0]       cond;
  logic             cond_neg;
  logic             nullify_req;
  logic             next_accept;
  logic             flush;
  logic [3:0]       cc_reg;
  logic             cond_true;
  logic             result_valid;
  logic             nullify_next;
  logic [CNT_W-1:0] null_count;

  modport master (
    output alu_valid, alu_flags, alu_lsb, update_cc, eval_en, use_live,
           cond, cond_neg, nullify_req, next_accept, flush,
    input  cc_reg, cond_true, result_valid, nullify_next, null_count
  );

  modport slave (
    input  alu_valid, alu_flags, alu_lsb, update_cc, eval_en, use_live,
           cond, cond_neg, nullify_req, next_accept, flush,
    output cc_reg, cond_true, result_valid, nullify_next, null_count
  );
endinterface

// File: rtl/cond_nullify_unit.sv
// EX-stage condition-code register, PA-RISC condition evaluator and nullify FSM.
// state | meaning: IDLE = no pending kill; ARMED = next accepted instruction is nullified.
module cond_nullify_unit #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  cond_nullify_unit_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cc_q, cc_d;
  logic             lsb_q, lsb_d;
  logic             cond_q, cond_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] f_sel;
  logic       l_sel;
  logic       dec;
  logic       result;
  logic       eval_acc;
  logic       cc_we;
  logic       null_w;

  // Flag order is {Z,N,C,V}.
  always_comb begin
    f_sel = bus.use_live ? bus.alu_flags : cc_q;
    l_sel = bus.use_live ? bus.alu_lsb   : lsb_q;
    dec   = 1'b0;
    unique case (bus.cond)
      3'b000: dec = 1'b0;
      3'b001: dec = f_sel[3];
      3'b010: dec = f_sel[2] ^ f_sel[0];
      3'b011: dec = f_sel[3] | (f_sel[2] ^ f_sel[0]);
      3'b100: dec = f_sel[1];
      3'b101: dec = f_sel[1] | f_sel[3];
      3'b110: dec = f_sel[0];
      3'b111: dec = l_sel;
      default: dec = 1'b0;
    endcase
    result = dec ^ bus.cond_neg;
  end

  // While ARMED the EX instruction is the one being killed, so its eval/update are dropped.
  always_comb begin
    eval_acc = bus.eval_en & (state_q == IDLE) & ~bus.flush;
    cc_we    = bus.alu_valid & bus.update_cc & (state_q == IDLE) & ~bus.flush;
    null_w   = (state_q == ARMED) & bus.next_accept & ~bus.flush;

    state_d = state_q;
    cc_d    = cc_q;
    lsb_d   = lsb_q;
    cond_d  = cond_q;
    rv_d    = 1'b0;
    cnt_d   = cnt_q;

    if (cc_we) begin
      cc_d  = bus.alu_flags;
      lsb_d = bus.alu_lsb;
    end

    if (eval_acc) begin
      cond_d = result;
      rv_d   = 1'b1;
    end

    if (null_w && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE:    if (eval_acc && bus.nullify_req && result) state_d = ARMED;
      ARMED:   if (bus.next_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cc_q    <= '0;
      lsb_q   <= 1'b0;
      cond_q  <= 1'b0;
      rv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      lsb_q   <= lsb_d;
      cond_q  <= cond_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cc_reg       = cc_q;
  assign bus.cond_true    = cond_q;
  assign bus.result_valid = rv_q;
  assign bus.nullify_next = null_w;
  assign bus.null_count   = cnt_q;

endmodule

// File: tb/tb_cond_nullify_unit.sv
// Scoreboard bench for cond_nullify_unit: expected conditions are queued with the cycle they are due.
// Counter width is reduced so saturation is reachable in a handful of nullifications.
module tb_cond_nullify_unit;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_nullify_unit_if #(.CNT_W(CW)) bus ();
  cond_nullify_unit #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic val;
    int   due;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc_n = 0;
  logic [3:0] cc_exp;
  logic       lsb_exp;
  int         cnt_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference condition table on {Z,N,C,V} and lsb.
  function automatic logic model(input logic [2:0] c, input logic neg,
                                 input logic [3:0] f, input logic l);
    logic z, n, cy, v, d;
    {z, n, cy, v} = f;
    case (c)
      3'd0: d = 1'b0;
      3'd1: d = z;
      3'd2: d = n ^ v;
      3'd3: d = z | (n ^ v);
      3'd4: d = cy;
      3'd5: d = cy | z;
      3'd6: d = v;
      default: d = l;
    endcase
    return d ^ neg;
  endfunction

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
        chk("rv", bus.result_valid, 1);
        chk("cond_true", bus.cond_true, sb[0].val);
        sb.delete(0);
      end else begin
        chk("rv_idle", bus.result_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_flags   = 4'b0;
    bus.alu_lsb     = 1'b0;
    bus.update_cc   = 1'b0;
    bus.eval_en     = 1'b0;
    bus.use_live    = 1'b0;
    bus.cond        = 3'b0;
    bus.cond_neg    = 1'b0;
    bus.nullify_req = 1'b0;
    bus.next_accept = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic rand_in();
    bus.alu_valid   = 1'($urandom);
    bus.alu_flags   = 4'($urandom);
    bus.alu_lsb     = 1'($urandom);
    bus.update_cc   = 1'($urandom);
    bus.eval_en     = 1'($urandom);
    bus.use_live    = 1'($urandom);
    bus.cond        = 3'($urandom);
    bus.cond_neg    = 1'($urandom);
    bus.nullify_req = 1'($urandom);
    bus.next_accept = 1'($urandom);
    bus.flush       = 1'($urandom);
  endtask

  task automatic drive_eval(input logic [2:0] c, input logic neg, input logic live,
                            input logic nreq);
    exp_t e;
    bus.eval_en     = 1'b1;
    bus.cond        = c;
    bus.cond_neg    = neg;
    bus.use_live    = live;
    bus.nullify_req = nreq;
    e.val = live ? model(c, neg, bus.alu_flags, bus.alu_lsb) : model(c, neg, cc_exp, lsb_exp);
    e.due = cyc_n + 1;
    sb.push_back(e);
  endtask

  task automatic arm();
    idle();
    drive_eval(3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    rand_in();
    tick();
    rand_in();
    tick();
    chk("rst_cc", bus.cc_reg, 0);
    chk("rst_cond", bus.cond_true, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_cnt", bus.null_count, 0);
    chk("rst_null", bus.nullify_next, 0);
    reset   = 1'b0;
    cc_exp  = 4'b0;
    lsb_exp = 1'b0;
    cnt_exp = 0;
    idle();

    bus.alu_valid = 1'b1; bus.update_cc = 1'b1; bus.alu_flags = 4'b1000; bus.alu_lsb = 1'b1;
    tick();
    idle();
    cc_exp = 4'b1000; lsb_exp = 1'b1;
    chk("cc_latch", bus.cc_reg, cc_exp);

    drive_eval(3'd1, 1'b0, 1'b0, 1'b0); tick();
    drive_eval(3'd1, 1'b1, 1'b0, 1'b0); tick();
    idle();

    bus.alu_flags = 4'b0101;
    drive_eval(3'd2, 1'b0, 1'b1, 1'b0); tick();
    drive_eval(3'd3, 1'b0, 1'b1, 1'b0); tick();
    drive_eval(3'd4, 1'b0, 1'b1, 1'b0); tick();
    drive_eval(3'd6, 1'b0, 1'b1, 1'b0); tick();
    bus.alu_flags = 4'b0010;
    drive_eval(3'd4, 1'b0, 1'b1, 1'b0); tick();
    drive_eval(3'd5, 1'b0, 1'b1, 1'b0); tick();
    idle();

    // Registered eval must see the old cc while the same edge writes new flags.
    bus.alu_valid = 1'b1; bus.update_cc = 1'b1; bus.alu_flags = 4'b0000; bus.alu_lsb = 1'b0;
    drive_eval(3'd1, 1'b0, 1'b0, 1'b0); tick();
    cc_exp = 4'b0000; lsb_exp = 1'b0;
    idle();
    drive_eval(3'd1, 1'b0, 1'b0, 1'b0); tick();
    drive_eval(3'd7, 1'b1, 1'b0, 1'b0); tick();
    idle();
    chk("cc_same_cycle", bus.cc_reg, cc_exp);

    drive_eval(3'd0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    bus.next_accept = 1'b1; #1;
    chk("no_arm_false", bus.nullify_next, 0);
    tick(); idle();

    arm();
    for (int i = 0; i < 3; i++) begin
      bus.eval_en = 1'b1; bus.cond = 3'd0; bus.cond_neg = 1'b1;
      bus.alu_valid = 1'b1; bus.update_cc = 1'b1; bus.alu_flags = 4'b1111;
      bus.next_accept = 1'b0; #1;
      chk("armed_hold", bus.nullify_next, 0);
      tick();
    end
    idle();
    chk("armed_no_cc", bus.cc_reg, cc_exp);
    bus.next_accept = 1'b1; bus.alu_valid = 1'b1; bus.update_cc = 1'b1; bus.alu_flags = 4'b1111; #1;
    chk("null_fire", bus.nullify_next, 1);
    tick(); idle();
    cnt_exp = 1;
    chk("null_cc", bus.cc_reg, cc_exp);
    chk("null_cnt", bus.null_count, cnt_exp);
    bus.next_accept = 1'b1; #1;
    chk("back_idle", bus.nullify_next, 0);
    tick(); idle();

    arm();
    bus.flush = 1'b1; bus.next_accept = 1'b1; #1;
    chk("flush_null", bus.nullify_next, 0);
    tick(); idle();
    chk("flush_cnt", bus.null_count, cnt_exp);
    bus.next_accept = 1'b1; #1;
    chk("flush_idle", bus.nullify_next, 0);
    tick(); idle();

    bus.flush = 1'b1; bus.eval_en = 1'b1; bus.cond = 3'd0; bus.cond_neg = 1'b1;
    tick(); idle();
    chk("flush_eval_rv", bus.result_valid, 0);

    for (int i = 0; i < 5; i++) begin
      arm();
      bus.next_accept = 1'b1; #1;
      chk("sat_fire", bus.nullify_next, 1);
      tick(); idle();
      cnt_exp = (cnt_exp < 3) ? cnt_exp + 1 : 3;
      chk("sat_cnt", bus.null_count, cnt_exp);
    end

    for (int i = 0; i < 24; i++) begin
      bus.alu_flags = 4'($urandom);
      bus.alu_lsb   = 1'($urandom);
      drive_eval(3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
